// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner sequencer for one shared N:1 mux channel.
// Issues a registered one-hot grant plus binary mux select, holds it until
// the owner releases, then idles the channel for one dead (GAP) cycle so the
// mux never switches directly between two owners.
// Optional feature macro: MUX_ARB_TIMEOUT_EN (force-release after HOLD_MAX
// BUSY cycles, flagged by a one-cycle timeout pulse).
module mux_rr_arbiter #(
    parameter int NREQ     = 4,
    parameter int SEL_W    = 2,
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  grant,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             timeout
);

    // Elaboration-time guard on the configuration space.
    if (NREQ != (1 << SEL_W) || NREQ < 2 || NREQ > 16 || HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_cfg
        $error("mux_rr_arbiter: illegal NREQ/SEL_W/HOLD_MAX combination");
    end

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] idx;
    logic             found;
    logic             rel;
    logic             force_rel;

    // Rotating-priority search: first set req bit at or above ptr, wrapping.
    // SEL_W-bit addition wraps naturally because NREQ is a power of two.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // sel holds the current owner while BUSY, so it doubles as the owner index.
    assign rel = done | ~req[sel];

`ifdef MUX_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    // Count BUSY cycles of the current grant; cleared as the grant is issued.
    always_ff @(posedge clk) begin
        if (rst)
            hold_cnt <= 8'd0;
        else if (state == IDLE && found)
            hold_cnt <= 8'd0;
        else if (state == BUSY)
            hold_cnt <= hold_cnt + 8'd1;
    end

    // A genuine release in the same cycle wins, so no timeout pulse then.
    assign force_rel = (state == BUSY) && (hold_cnt == 8'(HOLD_MAX - 1)) && !rel;
`else
    assign force_rel = 1'b0;
`endif

    // Owner FSM with registered grant/sel/valid/timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            grant   <= '0;
            sel     <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= NREQ'(1) << winner;
                        sel   <= winner;
                        valid <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (rel || force_rel) begin
                        grant   <= '0;
                        valid   <= 1'b0;
                        ptr     <= sel + SEL_W'(1);
                        timeout <= force_rel;
                        state   <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
